// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator for a one-byte command / one-byte response exchange.
// Optional response check enabled with `define RSP_CHECK_EN.
module spi_cmd_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int NCS_IDLE   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic [7:0] rsp,
    output logic       err,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ncs
);
    localparam int MAX1 = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int MAXV = (MAX1 > NCS_IDLE) ? MAX1 : NCS_IDLE;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [CW-1:0] L_ONE  = CW'(1);
    localparam logic [CW-1:0] L_DIV  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] L_GAP  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] L_IDLE = CW'(NCS_IDLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_GAP, S_RSP, S_HOLD, S_DONE
    } state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_tog, w_tog;
    logic [7:0]    r_sh, r_rx, r_rsp;
    logic          r_sck, r_mosi, r_ncs, r_busy, r_done;
    logic          w_sck, w_mosi, w_ncs, w_busy, w_done;
    logic          w_accept, w_shift, w_sample;

    // Pin values are decoded from the current state and registered, so every
    // output lags the state by one cycle; r_cnt doubles as the idle counter.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_tog    = r_tog;
        w_accept = 1'b0;
        w_shift  = 1'b0;
        w_sck    = 1'b0;
        w_mosi   = 1'b0;
        w_ncs    = 1'b0;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ncs  = 1'b1;
                w_busy = 1'b0;
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - L_ONE;
                end else if (start) begin
                    w_accept = 1'b1;
                    w_state  = S_SETUP;
                    w_cnt    = L_DIV;
                end
            end
            S_SETUP: begin
                w_mosi = r_sh[7];
                if (r_cnt == '0) begin
                    w_state = S_CMD;
                    w_cnt   = L_DIV;
                    w_tog   = 4'd0;
                end else begin
                    w_cnt = r_cnt - L_ONE;
                end
            end
            S_CMD: begin
                w_sck  = ~r_tog[0];
                w_mosi = r_sh[7];
                if (r_cnt == '0) begin
                    if (r_tog == 4'd15) begin
                        w_state = S_GAP;
                        w_cnt   = L_GAP;
                    end else begin
                        w_tog   = r_tog + 4'd1;
                        w_cnt   = L_DIV;
                        w_shift = ~r_tog[0];
                    end
                end else begin
                    w_cnt = r_cnt - L_ONE;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state = S_RSP;
                    w_cnt   = L_DIV;
                    w_tog   = 4'd0;
                end else begin
                    w_cnt = r_cnt - L_ONE;
                end
            end
            S_RSP: begin
                w_sck = ~r_tog[0];
                if (r_cnt == '0) begin
                    w_cnt = L_DIV;
                    if (r_tog == 4'd15) w_state = S_HOLD;
                    else                w_tog   = r_tog + 4'd1;
                end else begin
                    w_cnt = r_cnt - L_ONE;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) w_state = S_DONE;
                else             w_cnt   = r_cnt - L_ONE;
            end
            S_DONE: begin
                w_ncs   = 1'b1;
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = S_IDLE;
                w_cnt   = L_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        w_sample = (r_state == S_RSP) && w_sck && !r_sck;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tog   <= '0;
            r_sh    <= '0;
            r_rx    <= '0;
            r_rsp   <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_ncs   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_tog   <= w_tog;
            r_sck   <= w_sck;
            r_mosi  <= w_mosi;
            r_ncs   <= w_ncs;
            r_busy  <= w_busy;
            r_done  <= w_done;
            if (w_accept)     r_sh <= cmd;
            else if (w_shift) r_sh <= {r_sh[6:0], 1'b0};
            if (w_sample)     r_rx <= {r_rx[6:0], miso};
            if (w_done)       r_rsp <= r_rx;
        end
    end

`ifdef RSP_CHECK_EN
    logic [7:0] r_cmd;
    logic       r_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) r_cmd <= cmd;
            if (w_done)
                r_err <= !((r_cmd == 8'h06 && r_rx == 8'hD4) ||
                           (r_cmd == 8'hAA && r_rx == 8'hC4));
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign rsp  = r_rsp;
    assign sck  = r_sck;
    assign mosi = r_mosi;
    assign ncs  = r_ncs;
endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: SPI slave model plus frame-level reference model.
module tb_spi_cmd_master;
    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 16;
    localparam int NCS_IDLE   = 8;
    localparam int LAT        = 1 + 34*CLK_DIV + GAP_CYCLES;
    localparam int NCS_LOW    = 34*CLK_DIV + GAP_CYCLES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       busy, done, err, sck, mosi, miso, ncs;
    logic [7:0] rsp;

    int checks = 0;
    int failures = 0;

    spi_cmd_master #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .NCS_IDLE(NCS_IDLE)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .busy(busy), .done(done),
        .rsp(rsp), .err(err), .sck(sck), .mosi(mosi), .miso(miso), .ncs(ncs)
    );

    always #5 clk = ~clk;

    // Reference behaviour of the FPGA-side slave and of the response check.
    logic [7:0] sl_default = 8'h00;
    function automatic logic [7:0] exp_rsp(input logic [7:0] c, input logic [7:0] dflt);
        if (c == 8'h06)      return 8'hD4;
        else if (c == 8'hAA) return 8'hC4;
        else                 return dflt;
    endfunction
    function automatic logic exp_err(input logic [7:0] c, input logic [7:0] r);
`ifdef RSP_CHECK_EN
        return !((c == 8'h06 && r == 8'hD4) || (c == 8'hAA && r == 8'hC4));
`else
        return (c == 8'hFF) && (r == 8'hFF) && 1'b0;
`endif
    endfunction

    // Slave model, observing pins half a clock after they change.
    logic [7:0] sl_rx = 8'h00;
    logic [7:0] sl_tx = 8'h00;
    int         sl_edges = 0;
    int         sl_frame_edges = 0;
    logic       sl_psck = 1'b0;
    logic       sl_pncs = 1'b1;
    assign miso = sl_tx[7];

    always @(negedge clk) begin
        if (ncs) begin
            if (!sl_pncs) sl_frame_edges <= sl_edges;
            sl_edges <= 0;
            sl_tx    <= 8'h00;
        end else begin
            if (sck && !sl_psck) begin
                if (sl_edges < 8) sl_rx <= {sl_rx[6:0], mosi};
                if (sl_edges == 7) sl_tx <= exp_rsp({sl_rx[6:0], mosi}, sl_default);
                sl_edges <= sl_edges + 1;
            end
            if (!sck && sl_psck && sl_edges > 8) sl_tx <= {sl_tx[6:0], 1'b0};
        end
        sl_psck <= sck;
        sl_pncs <= ncs;
    end

    // Runs one frame and reports what it saw; comparisons live in the scenario tasks.
    task automatic run_frame(input logic [7:0] c, output int lat, output int low,
                             output logic [7:0] r, output logic e, output int bad_busy,
                             output logic done_after);
        @(negedge clk); start = 1'b1; cmd = c;
        @(negedge clk); start = 1'b0; cmd = 8'($urandom);
        lat = 0; low = 0; bad_busy = 0; r = 8'h00; e = 1'b0;
        for (int n = 1; n <= 400 && lat == 0; n++) begin
            @(negedge clk);
            if (!ncs) low++;
            if (busy !== !done) bad_busy++;
            if (done) begin lat = n; r = rsp; e = err; end
        end
        @(negedge clk);
        done_after = done;
        repeat (NCS_IDLE + 2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ncs !== 1'b1) begin failures++; $display("FAIL reset_ncs got=%b exp=1", ncs); end
        checks++; if (sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sck); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rsp !== 8'h00) begin failures++; $display("FAIL reset_rsp got=%h exp=00", rsp); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_cmds;
        logic [7:0] cmds[3] = '{8'h06, 8'hAA, 8'h55};
        logic [7:0] dfl[3]  = '{8'h11, 8'h22, 8'h00};
        int lat, low, bb; logic [7:0] r; logic e, d2;
        for (int i = 0; i < 3; i++) begin
            sl_default = dfl[i];
            run_frame(cmds[i], lat, low, r, e, bb, d2);
            checks++; if (sl_rx !== cmds[i]) begin failures++; $display("FAIL known_mosi cmd=%h got=%h exp=%h", cmds[i], sl_rx, cmds[i]); end
            checks++; if (r !== exp_rsp(cmds[i], dfl[i])) begin failures++; $display("FAIL known_rsp cmd=%h got=%h exp=%h", cmds[i], r, exp_rsp(cmds[i], dfl[i])); end
            checks++; if (e !== exp_err(cmds[i], r)) begin failures++; $display("FAIL known_err cmd=%h got=%b exp=%b", cmds[i], e, exp_err(cmds[i], r)); end
            checks++; if (lat != LAT) begin failures++; $display("FAIL known_latency cmd=%h got=%0d exp=%0d", cmds[i], lat, LAT); end
            checks++; if (low != NCS_LOW) begin failures++; $display("FAIL known_ncs_low cmd=%h got=%0d exp=%0d", cmds[i], low, NCS_LOW); end
            checks++; if (bb != 0) begin failures++; $display("FAIL known_busy cmd=%h bad_cycles=%0d exp=0", cmds[i], bb); end
            checks++; if (d2 !== 1'b0) begin failures++; $display("FAIL known_done_pulse cmd=%h got=%b exp=0", cmds[i], d2); end
            checks++; if (sl_frame_edges != 16) begin failures++; $display("FAIL known_sck_edges cmd=%h got=%0d exp=16", cmds[i], sl_frame_edges); end
        end
    endtask

    task automatic test_random;
        int lat, low, bb; logic [7:0] r, c; logic e, d2;
        for (int i = 0; i < 8; i++) begin
            c = (i % 4 == 0) ? 8'h06 : (i % 4 == 1) ? 8'hAA : 8'($urandom);
            sl_default = 8'($urandom);
            run_frame(c, lat, low, r, e, bb, d2);
            checks++; if (sl_rx !== c) begin failures++; $display("FAIL rand_mosi got=%h exp=%h", sl_rx, c); end
            checks++; if (r !== exp_rsp(c, sl_default)) begin failures++; $display("FAIL rand_rsp cmd=%h got=%h exp=%h", c, r, exp_rsp(c, sl_default)); end
            checks++; if (e !== exp_err(c, r)) begin failures++; $display("FAIL rand_err cmd=%h got=%b exp=%b", c, e, exp_err(c, r)); end
            checks++; if (lat != LAT || low != NCS_LOW) begin failures++; $display("FAIL rand_timing lat=%0d low=%0d exp=%0d/%0d", lat, low, LAT, NCS_LOW); end
        end
    endtask

    task automatic test_ignore_start;
        int dn, low; logic [7:0] r;
        sl_default = 8'h00; dn = 0; low = 0; r = 8'h00;
        @(negedge clk); start = 1'b1; cmd = 8'h06;
        @(negedge clk); start = 1'b0; cmd = 8'h00;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 20) begin start = 1'b1; cmd = 8'h99; end
            if (n == 21) start = 1'b0;
            if (!ncs) low++;
            if (done) begin dn++; r = rsp; end
        end
        checks++; if (dn != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dn); end
        checks++; if (sl_rx !== 8'h06) begin failures++; $display("FAIL ignore_wire_cmd got=%h exp=06", sl_rx); end
        checks++; if (r !== 8'hD4) begin failures++; $display("FAIL ignore_rsp got=%h exp=d4", r); end
        checks++; if (low != NCS_LOW) begin failures++; $display("FAIL ignore_ncs_low got=%0d exp=%0d", low, NCS_LOW); end
    endtask

    task automatic test_reset_mid;
        int dn, low, lat, bb; logic [7:0] r; logic e, d2;
        sl_default = 8'h00; dn = 0; low = 0;
        @(negedge clk); start = 1'b1; cmd = 8'hAA;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n < 60; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ncs !== 1'b1 || sck !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_pins ncs=%b sck=%b busy=%b exp=1/0/0", ncs, sck, busy); end
        rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) dn++;
            if (!ncs) low++;
        end
        checks++; if (dn != 0 || low != 0) begin failures++; $display("FAIL midrst_quiet done=%0d ncs_low=%0d exp=0/0", dn, low); end
        run_frame(8'h06, lat, low, r, e, bb, d2);
        checks++; if (r !== 8'hD4 || lat != LAT) begin failures++; $display("FAIL midrst_recover rsp=%h lat=%0d exp=d4/%0d", r, lat, LAT); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] list[3] = '{8'h06, 8'hAA, 8'h3C};
        int dn, hi, gaps;
        sl_default = 8'h5A; dn = 0; hi = 0; gaps = 0;
        @(negedge clk); start = 1'b1; cmd = list[0];
        for (int n = 0; n < 1500 && dn < 3; n++) begin
            @(negedge clk);
            if (done) begin
                checks++; if (rsp !== exp_rsp(list[dn], sl_default) || err !== exp_err(list[dn], rsp)) begin
                    failures++; $display("FAIL b2b_rsp frame=%0d got=%h/%b exp=%h/%b", dn, rsp, err,
                                         exp_rsp(list[dn], sl_default), exp_err(list[dn], exp_rsp(list[dn], sl_default)));
                end
                dn++;
                if (dn < 3) cmd = list[dn];
                else start = 1'b0;
            end
            if (ncs) hi++;
            else begin
                if (dn > 0 && hi > 0) begin
                    gaps++;
                    checks++; if (hi != NCS_IDLE + 1) begin failures++; $display("FAIL b2b_ncs_high got=%0d exp=%0d", hi, NCS_IDLE + 1); end
                end
                hi = 0;
            end
        end
        start = 1'b0;
        checks++; if (dn != 3 || gaps != 2) begin failures++; $display("FAIL b2b_frames done=%0d gaps=%0d exp=3/2", dn, gaps); end
        repeat (NCS_IDLE + 2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_known_cmds();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
